// File: rtl/vive_rx_pkg.sv
// Shared defaults, FSM encoding and helpers for the triad receive path.
package vive_rx_pkg;

   localparam int unsigned FRAME_W_DEF = 102;
   localparam int unsigned TS_W_DEF    = 24;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } arb_state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p << 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/triad_frame_arbiter_if.sv
// Transmitter-side handshake: tagged frame presented until a one-cycle ack.
interface triad_frame_arbiter_if
   import vive_rx_pkg::*;
#(
   parameter int unsigned ID_W    = 3,
   parameter int unsigned FRAME_W = FRAME_W_DEF
);

   logic                    tx_data_avl;
   logic [ID_W+FRAME_W-1:0] tx_frame;
   logic                    tx_ack;

   modport master (output tx_data_avl, output tx_frame, input tx_ack);
   modport slave  (input tx_data_avl, input tx_frame, output tx_ack);

endinterface

// File: rtl/triad_frame_arbiter_rr.sv
// Combinational round-robin pick: first request after the last grant, with wrap.
module rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 3
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_vld_o
);

   int unsigned best_d;
   int unsigned best_i;
   int unsigned d;

   // Rank each requester by its distance past the last grant; nearest wins.
   always_comb begin
      best_d    = N;
      best_i    = 0;
      d         = 0;
      gnt_o     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         d = (i + 2 * N - 1 - 32'(last_i)) % N;
         if (req_i[i] && (d < best_d)) begin
            best_d = d;
            best_i = i;
         end
      end
      gnt_vld_o = (best_d < N);
      gnt_idx_o = IDX_W'(best_i);
      for (int unsigned i = 0; i < N; i++) begin
         gnt_o[i] = gnt_vld_o && (best_i == i);
      end
   end

endmodule

// File: rtl/triad_frame_arbiter.sv
// Collects frames from NUM_TRIADS triad managers into per-channel slots and
// forwards them, tagged with the channel index, to one serial transmitter.
module triad_frame_arbiter
   import vive_rx_pkg::*;
#(
   parameter int unsigned NUM_TRIADS = 4,
   parameter int unsigned FRAME_W    = FRAME_W_DEF,
   parameter int unsigned ID_W       = 3,
   parameter int unsigned TS_W       = TS_W_DEF,
   parameter int unsigned DROP_MODE  = 0,
   parameter int unsigned DROP_CNT_W = 8
) (
   input  logic                           clk_96MHz,
   input  logic                           reset,
   input  logic [NUM_TRIADS-1:0]          data_avl,
   input  logic [NUM_TRIADS*FRAME_W-1:0]  sensor_iterations,
   output logic [NUM_TRIADS-1:0]          reset_parser,
   output logic [TS_W-1:0]                sys_ts,
   triad_frame_arbiter_if.master          tx,
   output logic [NUM_TRIADS*DROP_CNT_W-1:0] drop_count
);

   logic [TS_W-1:0]               sys_ts_q;
   logic [NUM_TRIADS-1:0]         full;
   logic [NUM_TRIADS*FRAME_W-1:0] slot_flat;
   logic [NUM_TRIADS-1:0]         req;
   logic [NUM_TRIADS-1:0]         gnt;
   logic [ID_W-1:0]               gnt_idx;
   logic                          gnt_vld;
   logic [FRAME_W-1:0]            gnt_frame;

   arb_state_e                    state_q;
   logic [ID_W-1:0]               rr_q;
   logic                          tx_vld_q;
   logic [ID_W+FRAME_W-1:0]       tx_frame_q;

   // Free-running timestamp broadcast to every triad.
   always_ff @(posedge clk_96MHz) begin
      if (reset) sys_ts_q <= '0;
      else       sys_ts_q <= sys_ts_q + 1'b1;
   end

   assign sys_ts = sys_ts_q;

   for (genvar gi = 0; gi < NUM_TRIADS; gi++) begin : g_ch
      logic [FRAME_W-1:0]    slot_q;
      logic                  full_q;
      logic                  armed_q;
      logic                  ack_q;
      logic [DROP_CNT_W-1:0] drop_q;
      logic                  cap;

      assign cap = data_avl[gi] && armed_q && (!full_q || (DROP_MODE != 0));

      // Slot capture, one-shot ack, re-arm on low level, saturating drop count.
      // A capture on the cycle the slot is granted refills it: full stays set
      // and, since the old contents were forwarded, it is not a drop.
      always_ff @(posedge clk_96MHz) begin
         if (reset) begin
            slot_q  <= '0;
            full_q  <= 1'b0;
            armed_q <= 1'b1;
            ack_q   <= 1'b0;
            drop_q  <= '0;
         end else begin
            ack_q <= cap;
            if (cap) begin
               slot_q  <= sensor_iterations[gi*FRAME_W +: FRAME_W];
               full_q  <= 1'b1;
               armed_q <= 1'b0;
            end else begin
               if (gnt[gi])       full_q  <= 1'b0;
               if (!data_avl[gi]) armed_q <= 1'b1;
            end
            if (cap && full_q && !gnt[gi] && (drop_q != '1)) begin
               drop_q <= drop_q + 1'b1;
            end
         end
      end

      assign full[gi]                                 = full_q;
      assign reset_parser[gi]                         = ack_q;
      assign slot_flat[gi*FRAME_W +: FRAME_W]         = slot_q;
      assign drop_count[gi*DROP_CNT_W +: DROP_CNT_W]  = drop_q;
   end

   assign req = full & {NUM_TRIADS{state_q == ST_IDLE}};

   rr_arbiter #(
      .N     (NUM_TRIADS),
      .IDX_W (ID_W)
   ) u_rr (
      .req_i     (req),
      .last_i    (rr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   // Select the granted slot contents.
   always_comb begin
      gnt_frame = '0;
      for (int unsigned i = 0; i < NUM_TRIADS; i++) begin
         if (gnt[i]) gnt_frame = slot_flat[i*FRAME_W +: FRAME_W];
      end
   end

   // Presentation FSM: latch the granted frame, hold it until the ack.
   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rr_q       <= ID_W'(NUM_TRIADS - 1);
         tx_vld_q   <= 1'b0;
         tx_frame_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt_vld) begin
                  tx_frame_q <= {gnt_idx, gnt_frame};
                  rr_q       <= gnt_idx;
                  tx_vld_q   <= 1'b1;
                  state_q    <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (tx.tx_ack) begin
                  tx_vld_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign tx.tx_data_avl = tx_vld_q;
   assign tx.tx_frame    = tx_frame_q;

endmodule
